// File: rtl/bcd_to_bin_converter.sv
// Sequential packed-BCD to binary converter: one multiply-by-10-and-add step per digit, MSD first.
// Optional macro BCD_CHECK_EN flags digits above 9 on err_out; without it err_out is tied low.
module bcd_to_bin_converter #(
    parameter int DIGITS = 2,
    parameter int BIN_W  = 7
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*DIGITS-1:0]   bcd_in,
    input  logic                  valid_in,
    output logic                  ready_in,
    output logic [BIN_W-1:0]      bin_out,
    output logic                  valid_out,
    input  logic                  ready_out,
    output logic                  err_out
);

    localparam int CNT_W = $clog2(DIGITS + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIGITS - 1);

`ifdef BCD_CHECK_EN
    localparam logic CHECK_EN = 1'b1;
`else
    localparam logic CHECK_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                 state_r;
    logic [BIN_W-1:0]       acc_r;
    logic [CNT_W-1:0]       cnt_r;
    logic [4*DIGITS-1:0]    shift_r;
    logic                   err_r;
    logic [BIN_W-1:0]       bin_out_r;
    logic                   err_out_r;
    logic                   valid_out_r;

    logic [3:0]             digit_s;
    logic [BIN_W-1:0]       acc_next_s;
    logic                   err_next_s;

    function automatic logic digit_invalid(input logic [3:0] d);
        return (d > 4'd9);
    endfunction

    // Next accumulator value and error flag for the digit currently at the top of the shift register
    always_comb begin
        digit_s    = shift_r[4*DIGITS-1 -: 4];
        acc_next_s = (acc_r << 3) + (acc_r << 1) + BIN_W'(digit_s);
        if (CHECK_EN) begin
            err_next_s = err_r | digit_invalid(digit_s);
        end else begin
            err_next_s = 1'b0;
        end
    end

    // Control FSM with conversion datapath and registered result outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            acc_r       <= '0;
            cnt_r       <= '0;
            shift_r     <= '0;
            err_r       <= 1'b0;
            bin_out_r   <= '0;
            err_out_r   <= 1'b0;
            valid_out_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (valid_in) begin
                        shift_r <= bcd_in;
                        acc_r   <= '0;
                        cnt_r   <= '0;
                        err_r   <= 1'b0;
                        state_r <= CONV;
                    end
                end
                CONV: begin
                    acc_r   <= acc_next_s;
                    shift_r <= shift_r << 4;
                    cnt_r   <= cnt_r + CNT_W'(1);
                    err_r   <= err_next_s;
                    // Final digit: publish the result in the same edge that enters DONE
                    if (cnt_r == LAST_CNT) begin
                        state_r     <= DONE;
                        bin_out_r   <= acc_next_s;
                        err_out_r   <= err_next_s;
                        valid_out_r <= 1'b1;
                    end
                end
                DONE: begin
                    if (ready_out) begin
                        state_r     <= IDLE;
                        valid_out_r <= 1'b0;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    valid_out_r <= 1'b0;
                end
            endcase
        end
    end

    assign ready_in  = (state_r == IDLE);
    assign bin_out   = bin_out_r;
    assign err_out   = err_out_r;
    assign valid_out = valid_out_r;

endmodule

// File: doc/bcd_to_bin_converter.md
Name: bcd_to_bin_converter

Overview:
- Sequential converter from packed multi-digit BCD to unsigned binary; the inverse of the team's BCD adder output format.
- Accepts one BCD word per transaction over a valid/ready input handshake and returns the binary value over a valid/ready output handshake.
- Uses one multiply-by-10-and-add step per digit, most significant digit first.
- Sits between BCD arithmetic/display blocks and binary datapath logic.

Parameters:
- DIGITS, 2: number of BCD digits in bcd_in; must be 1 or more.
- BIN_W, 7: width of bin_out; must be at least ceil(log2(10^DIGITS)). Default 7 covers 99. The RTL does not check this.

Ports:
- clk, input, 1: sole clock; all state updates on the rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- bcd_in, input, 4*DIGITS: packed BCD word; bits [4*DIGITS-1 -: 4] hold the most significant digit.
- valid_in, input, 1: bcd_in is valid.
- ready_in, output, 1: converter can accept a word.
- bin_out, output, BIN_W: converted binary result.
- valid_out, output, 1: bin_out (and err_out) are valid.
- ready_out, input, 1: downstream accepts the result.
- err_out, output, 1: at least one input digit was greater than 9; qualified by valid_out.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE, acc = 0, digit counter = 0, shift register = 0, error flag = 0.
  - Outputs: valid_out = 0, bin_out = 0, err_out = 0.
  - ready_in = (state == IDLE), so ready_in reads 1 while in reset.
- IDLE:
  - ready_in = 1, valid_out = 0.
  - On an edge with valid_in = 1, capture bcd_in into the shift register; clear acc, counter and error flag; go to CONV.
- CONV:
  - ready_in = 0, valid_out = 0.
  - Each edge: acc = (acc<<3) + (acc<<1) + top digit, truncated to BIN_W bits; shift register left by 4; counter + 1.
  - With BCD_CHECK_EN, OR (top digit > 9) into the error flag.
  - On the edge where the counter reaches DIGITS: go to DONE, and register bin_out = final acc and err_out = error flag.
- DONE:
  - valid_out = 1, ready_in = 0.
  - bin_out and err_out held stable until accepted.
  - On an edge with ready_out = 1: go to IDLE; valid_out deasserts on that edge.
- Latency:
  - Word accepted at edge k gives valid_out = 1 after edge k+DIGITS.
  - Minimum transaction period is DIGITS+2 cycles: accept, DIGITS conversion steps, hand-off. No overlap: a new word cannot be accepted in the cycle the result is taken.
- valid_in while ready_in = 0 is ignored; there is no queueing.
- ready_out while valid_out = 0 has no effect.
- Arithmetic: acc is BIN_W bits and wraps modulo 2^BIN_W. Non-decimal digits (A–F) are used at face value (10–15); no saturation.
- Reset mid-CONV or mid-DONE: the transaction is aborted; valid_out never asserts for it; IDLE follows reset release.

Optional Feature:
- Macro: BCD_CHECK_EN
- Defined:
  - Per-digit > 9 comparators are built.
  - err_out = 1 for a transaction containing any digit from 10 to 15.
  - bin_out is still computed arithmetically.
- Not defined:
  - No check logic is built.
  - err_out is tied to 0; port list unchanged.

Test Plan:
1. Defaults, bcd_in = 0x99, valid_in one cycle, ready_out = 1 → valid_out high exactly 2 edges after acceptance, bin_out = 99 (7'h63), err_out = 0; back in IDLE one cycle later.
2. bcd_in = 0x00 → bin_out = 0; then bcd_in = 0x01 → bin_out = 1, confirming back-to-back transactions with period DIGITS+2 = 4 cycles.
3. bcd_in = 0x47 with ready_out held 0 for 5 cycles while valid_in toggles with 0x12 →
   - bin_out = 47 stable throughout; ready_in = 0; 0x12 not captured.
   - After ready_out = 1, the next accepted word converts correctly.
4. bcd_in = 0x3A →
   - With BCD_CHECK_EN: err_out = 1, bin_out = 40.
   - Without: err_out = 0, bin_out = 40.
   - A following 0x25 gives err_out = 0, bin_out = 25.
5. Assert rst_n low mid-CONV on 0x88 →
   - Immediately: valid_out = 0, bin_out = 0.
   - After release: ready_in = 1, no stale result; next word 0x63 gives bin_out = 63.
6. DIGITS = 3, BIN_W = 10:
   - bcd_in = 0x999 → bin_out = 999 (10'h3E7), valid_out 3 edges after acceptance.
   - bcd_in = 0x100 → bin_out = 100.
